vec_product_sched: RTL and testbench

Sequencer that drives one shared vec_product dot-product datapath to compute a full M x N score tile, C[i][j] = dot(A_row[i], B_col[j]). It fetches packed 256-bit operand vectors from the A and B operand buffers and registers them into the vec_product inputs. It captures each signed result and streams it out with row/col tags under a valid/ready handshake. It sits between the attention-tile control logic, the operand SRAMs and the vec_product instance.

---
 rtl/vec_product_sched.sv | 152 +++++++++++++++
 tb/tb_vec_product_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_product_sched.sv
// Sequencer for a shared vec_product datapath: walks an M x N score tile,
// fetches A/B operand vectors and streams tagged dot products downstream.
module vec_product_sched #(
    parameter int BIT_WIDTH = 4,
    parameter int VEC_SIZE  = 64,
    parameter int RES_WIDTH = BIT_WIDTH * 2 + $clog2(VEC_SIZE),
    parameter int DIM_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic [DIM_WIDTH-1:0]           i_rows,
    input  logic [DIM_WIDTH-1:0]           i_cols,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_a_ren,
    output logic [DIM_WIDTH-1:0]           o_a_addr,
    input  logic [BIT_WIDTH*VEC_SIZE-1:0]  i_a_data,
    output logic                           o_b_ren,
    output logic [DIM_WIDTH-1:0]           o_b_addr,
    input  logic [BIT_WIDTH*VEC_SIZE-1:0]  i_b_data,
    output logic [BIT_WIDTH*VEC_SIZE-1:0]  o_vp_a,
    output logic [BIT_WIDTH*VEC_SIZE-1:0]  o_vp_b,
    input  logic [RES_WIDTH-1:0]           i_vp_product,
    output logic                           o_res_valid,
    input  logic                           i_res_ready,
    output logic [RES_WIDTH-1:0]           o_res_data,
    output logic [DIM_WIDTH-1:0]           o_res_row,
    output logic [DIM_WIDTH-1:0]           o_res_col
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [DIM_WIDTH-1:0]   rows_q;
    logic [DIM_WIDTH-1:0]   cols_q;
    logic [DIM_WIDTH-1:0]   i_q;
    logic [DIM_WIDTH-1:0]   j_q;
    logic                   f_valid;
    logic [DIM_WIDTH-1:0]   f_row;
    logic [DIM_WIDTH-1:0]   f_col;
    logic                   d_valid;
    logic [DIM_WIDTH-1:0]   d_row;
    logic [DIM_WIDTH-1:0]   d_col;
    logic                   advance;
    logic                   issue;
    logic                   last_col;
    logic                   last_pair;
    logic                   drained;

    assign advance   = !o_res_valid || i_res_ready;
    assign issue     = (state == RUN) && advance;
    assign last_col  = (j_q == cols_q - DIM_WIDTH'(1));
    assign last_pair = last_col && (i_q == rows_q - DIM_WIDTH'(1));
    // advance already folds in the final handshake of the output stage
    assign drained   = !f_valid && !d_valid && advance;

    assign o_a_ren  = issue;
    assign o_b_ren  = issue;
    assign o_a_addr = i_q;
    assign o_b_addr = j_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            rows_q <= '0;
            cols_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rows_q <= i_rows;
                        cols_q <= i_cols;
                        i_q    <= '0;
                        j_q    <= '0;
                        o_busy <= 1'b1;
                        if (i_rows == '0 || i_cols == '0) state <= DONE;
                        else                               state <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (last_pair) begin
                            state <= DRAIN;
                        end else if (last_col) begin
                            j_q <= '0;
                            i_q <= i_q + DIM_WIDTH'(1);
                        end else begin
                            j_q <= j_q + DIM_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    // empty jobs arrive here with o_done low and pulse it next cycle
                    if (o_done) begin
                        o_done <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_valid     <= 1'b0;
            f_row       <= '0;
            f_col       <= '0;
            d_valid     <= 1'b0;
            d_row       <= '0;
            d_col       <= '0;
            o_vp_a      <= '0;
            o_vp_b      <= '0;
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
            o_res_row   <= '0;
            o_res_col   <= '0;
        end else if (advance) begin
            f_valid     <= issue;
            f_row       <= i_q;
            f_col       <= j_q;
            d_valid     <= f_valid;
            o_res_valid <= d_valid;
            if (f_valid) begin
                o_vp_a <= i_a_data;
                o_vp_b <= i_b_data;
                d_row  <= f_row;
                d_col  <= f_col;
            end
            if (d_valid) begin
                o_res_data <= i_vp_product;
                o_res_row  <= d_row;
                o_res_col  <= d_col;
            end
        end
    end

endmodule

// File: tb/tb_vec_product_sched.sv
// Bench for vec_product_sched: operand buffers, a behavioural dot product,
// and a scoreboard of expected tile results in row-major order.
module tb_vec_product_sched;

    localparam int BW = 4;
    localparam int VS = 64;
    localparam int RW = 14;
    localparam int DW = 8;
    localparam int VW = BW * VS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] rows;
    logic [DW-1:0] cols;
    logic          busy;
    logic          done;
    logic          a_ren;
    logic [DW-1:0] a_addr;
    logic [VW-1:0] a_data;
    logic          b_ren;
    logic [DW-1:0] b_addr;
    logic [VW-1:0] b_data;
    logic [VW-1:0] vp_a;
    logic [VW-1:0] vp_b;
    logic [RW-1:0] vp_product;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic [DW-1:0] res_row;
    logic [DW-1:0] res_col;

    vec_product_sched dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_rows       (rows),
        .i_cols       (cols),
        .o_busy       (busy),
        .o_done       (done),
        .o_a_ren      (a_ren),
        .o_a_addr     (a_addr),
        .i_a_data     (a_data),
        .o_b_ren      (b_ren),
        .o_b_addr     (b_addr),
        .i_b_data     (b_data),
        .o_vp_a       (vp_a),
        .o_vp_b       (vp_b),
        .i_vp_product (vp_product),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_data   (res_data),
        .o_res_row    (res_row),
        .o_res_col    (res_col)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] a_mem [0:15];
    logic [VW-1:0] b_mem [0:15];
    int            a_val [0:15];
    int            b_val [0:15];

    always @(posedge clk) begin
        if (a_ren) a_data <= a_mem[a_addr[3:0]];
        if (b_ren) b_data <= b_mem[b_addr[3:0]];
    end

    always_comb begin
        int s;
        s = 0;
        for (int k = 0; k < VS; k++)
            s += $signed(vp_a[k*BW +: BW]) * $signed(vp_b[k*BW +: BW]);
        vp_product = s[RW-1:0];
    end

    typedef struct {
        int row;
        int col;
        int val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   last_hs_cyc = -1;
    int   first_ren_cyc = -1;
    int   first_val_cyc = -1;
    int   start_cyc = 0;
    int   n_res = 0;
    int   rdy_mode = 0;
    int   rp = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rp++;
        case (rdy_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = (rp % 4 == 0) || (rp % 4 == 3);
            default: res_ready = 1'b0;
        endcase
    end

    logic          stalled_prev = 1'b0;
    logic [RW-1:0] held_data;
    logic [DW-1:0] held_row;
    logic [DW-1:0] held_col;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (a_ren && first_ren_cyc < 0) first_ren_cyc = cyc;
            if (res_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (stalled_prev) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_data", int'(res_data), int'(held_data));
                chk("hold_row", int'(res_row), int'(held_row));
                chk("hold_col", int'(res_col), int'(held_col));
            end
            if (res_valid && !res_ready) chk("stall_ren", int'(a_ren), 0);
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_data", int'($signed(res_data)), e.val);
                    chk("res_row", int'(res_row), e.row);
                    chk("res_col", int'(res_col), e.col);
                end
                last_hs_cyc = cyc;
                n_res++;
            end
            stalled_prev = res_valid && !res_ready;
            held_data = res_data;
            held_row  = res_row;
            held_col  = res_col;
        end
    end

    task automatic set_a(input int idx, input int v);
        logic [BW-1:0] e;
        e = BW'(v);
        a_mem[idx] = {VS{e}};
        a_val[idx] = v;
    endtask

    task automatic set_b(input int idx, input int v);
        logic [BW-1:0] e;
        e = BW'(v);
        b_mem[idx] = {VS{e}};
        b_val[idx] = v;
    endtask

    task automatic start_job(input int r, input int c);
        @(posedge clk);
        #1;
        rows = DW'(r);
        cols = DW'(c);
        start = 1'b1;
        first_ren_cyc = -1;
        first_val_cyc = -1;
        n_res = 0;
        start_cyc = cyc;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                q.push_back('{row: i, col: j, val: VS * a_val[i] * b_val[j]});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        rows = '0;
        cols = '0;
        res_ready = 1'b1;
        a_data = '0;
        b_data = '0;
        for (int k = 0; k < 16; k++) begin
            set_a(k, 0);
            set_b(k, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ren", int'(a_ren | b_ren), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_vp", int'(|{vp_a, vp_b}), 0);
        chk("rst_res", int'(|{res_data, res_row, res_col}), 0);
        rst_n = 1'b1;

        // basic 2x3 tile
        set_a(0, 1);
        set_a(1, -2);
        for (int j = 0; j < 3; j++) set_b(j, j + 1);
        rdy_mode = 0;
        start_job(2, 3);
        wait_done(100);
        chk("t1_count", n_res, 6);
        chk("t1_latency", first_val_cyc - first_ren_cyc, 3);
        chk("t1_done_lat", done_cyc - last_hs_cyc, 1);
        chk("t1_q_empty", q.size(), 0);

        // signed extremes
        set_a(0, -8);
        set_b(0, -8);
        set_b(1, 7);
        start_job(1, 2);
        wait_done(100);
        chk("t2_count", n_res, 2);

        // backpressure
        set_a(0, 3);
        for (int j = 0; j < 4; j++) set_b(j, 4 - j * 3);
        rdy_mode = 1;
        start_job(1, 4);
        wait_done(200);
        chk("t3_count", n_res, 4);
        chk("t3_q_empty", q.size(), 0);
        rdy_mode = 0;

        // zero dimension
        start_job(0, 5);
        wait_done(50);
        chk("t4_done_lat", done_cyc - start_cyc, 2);
        chk("t4_no_ren", first_ren_cyc, -1);
        chk("t4_no_valid", first_val_cyc, -1);

        // start ignored while running
        set_a(0, 5);
        set_a(1, -7);
        for (int j = 0; j < 3; j++) set_b(j, j - 1);
        rdy_mode = 1;
        start_job(2, 3);
        #1;
        rows = 8'd9;
        cols = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        wait_done(300);
        repeat (10) @(posedge clk);
        chk("t5_count", n_res, 6);
        chk("t5_q_empty", q.size(), 0);
        chk("t5_one_done", done_cnt - d0, 1);
        rdy_mode = 0;

        // reset while draining
        rdy_mode = 2;
        set_a(0, 2);
        set_b(0, 2);
        set_b(1, 3);
        start_job(1, 2);
        repeat (6) @(posedge clk);
        #3;
        chk("t6_stuck", int'(res_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(res_valid), 0);
        chk("t6_ren", int'(a_ren), 0);
        chk("t6_res", int'(res_data), 0);
        chk("t6_vp", int'(|vp_a), 0);
        q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_idle", int'(busy), 0);

        // fresh job after reset
        set_a(0, -3);
        set_b(0, 6);
        start_job(1, 1);
        wait_done(50);
        chk("t7_count", n_res, 1);
        chk("t7_q_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
